// File: rtl/fmc_arbiter.sv
// Round-robin arbiter sharing one fmc port among NUM_REQ requesters, one access in flight.
// Optional access timeout is compiled in with `define FMC_TIMEOUT_EN.
module fmc_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      err,
  output logic                      fmc_ce,
  output logic                      fmc_oe,
  output logic                      fmc_we,
  output logic [ADDR_W-1:0]         fmc_addr,
  output logic [DATA_W-1:0]         fmc_wdata,
  input  logic [DATA_W-1:0]         fmc_rdata,
  input  logic                      fmc_ready,
  output logic [1:0]                dbg_state
);

  // Handshake: a requester raises req with its command stable and holds it until
  // its done pulse; the command is captured on the granting edge, so later changes
  // to req/req_we/req_addr/req_wdata do not affect the access already in flight.

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic [DATA_W-1:0]  rdata_d;
  logic               busy_d, ce_d, oe_d, we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

`ifdef FMC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? 16 : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign dbg_state = state_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Scan starts just past the last winner, so the previous grantee has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt;
    done_d  = '0;
    rdata_d = rdata;
    ce_d    = fmc_ce;
    oe_d    = fmc_oe;
    we_d    = fmc_we;
    addr_d  = fmc_addr;
    wdata_d = fmc_wdata;
`ifdef FMC_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          sel_d          = win_idx;
          ptr_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          ce_d           = 1'b1;
          oe_d           = ~req_we[win_idx];
          we_d           = req_we[win_idx];
          addr_d         = addr_arr[win_idx];
          wdata_d        = wdata_arr[win_idx];
`ifdef FMC_TIMEOUT_EN
          cnt_d          = '0;
`endif
          state_d        = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (fmc_ready) begin
          if (!fmc_we) rdata_d = fmc_rdata;
          done_d[sel_q] = 1'b1;
          gnt_d         = '0;
          ce_d          = 1'b0;
          oe_d          = 1'b0;
          we_d          = 1'b0;
          state_d       = ST_RECOVER;
        end
`ifdef FMC_TIMEOUT_EN
        // Ready on the expiry edge takes the branch above, so it completes normally.
        else if (cnt_q == CNT_LAST) begin
          done_d[sel_q] = 1'b1;
          err_d         = 1'b1;
          gnt_d         = '0;
          ce_d          = 1'b0;
          oe_d          = 1'b0;
          we_d          = 1'b0;
          state_d       = ST_RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      sel_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      fmc_ce    <= 1'b0;
      fmc_oe    <= 1'b0;
      fmc_we    <= 1'b0;
      fmc_addr  <= '0;
      fmc_wdata <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt       <= gnt_d;
      done      <= done_d;
      rdata     <= rdata_d;
      busy      <= busy_d;
      fmc_ce    <= ce_d;
      fmc_oe    <= oe_d;
      fmc_we    <= we_d;
      fmc_addr  <= addr_d;
      fmc_wdata <= wdata_d;
    end
  end

`ifdef FMC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
